// File: rtl/axi_lite_arb2.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_arb2
// Description : Two-master to one-slave AXI4-Lite arbiter. Independent write
//               (AW/W/B) and read (AR/R) arbiters, each round-robin between
//               the two masters. A grant is held until that transaction's
//               response handshake completes. Valid/ready/payload are routed
//               combinationally from the registered grant and phase.
// Ports       : clk, reset          - clock, synchronous active-high reset
//               m_aw*/m_w*/m_b*     - per-master write channels (bit/slice i)
//               m_ar*/m_r*          - per-master read channels (bit/slice i)
//               s_aw*/s_w*/s_b*     - slave-side write channels
//               s_ar*/s_r*          - slave-side read channels
//               wr_grant, rd_grant  - current owner index (meaningful when busy)
//               wr_busy, rd_busy    - arbiter not idle
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_arb2 #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 32,
  parameter int ID_SIZE   = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  // master-side write address
  input  logic [1:0]             m_awvalid,
  input  logic [2*ADDR_SIZE-1:0] m_awaddr,
  input  logic [2*ID_SIZE-1:0]   m_awid,
  input  logic [1:0]             m_awsize,
  output logic [1:0]             m_awready,
  // master-side write data
  input  logic [1:0]             m_wvalid,
  input  logic [2*DATA_SIZE-1:0] m_wdata,
  input  logic [1:0]             m_wlast,
  output logic [1:0]             m_wready,
  // master-side write response
  output logic [1:0]             m_bvalid,
  output logic [1:0]             m_bresp,
  output logic [2*ID_SIZE-1:0]   m_bid,
  input  logic [1:0]             m_bready,
  // master-side read address
  input  logic [1:0]             m_arvalid,
  input  logic [2*ADDR_SIZE-1:0] m_araddr,
  input  logic [2*ID_SIZE-1:0]   m_arid,
  input  logic [1:0]             m_arsize,
  output logic [1:0]             m_arready,
  // master-side read data
  output logic [1:0]             m_rvalid,
  output logic [2*DATA_SIZE-1:0] m_rdata,
  output logic [1:0]             m_rlast,
  output logic [2*ID_SIZE-1:0]   m_rid,
  output logic [1:0]             m_rresp,
  input  logic [1:0]             m_rready,
  // slave-side write address
  output logic                   s_awvalid,
  output logic [ADDR_SIZE-1:0]   s_awaddr,
  output logic [ID_SIZE-1:0]     s_awid,
  output logic                   s_awsize,
  input  logic                   s_awready,
  // slave-side write data
  output logic                   s_wvalid,
  output logic [DATA_SIZE-1:0]   s_wdata,
  output logic                   s_wlast,
  input  logic                   s_wready,
  // slave-side write response
  input  logic                   s_bvalid,
  input  logic                   s_bresp,
  input  logic [ID_SIZE-1:0]     s_bid,
  output logic                   s_bready,
  // slave-side read address
  output logic                   s_arvalid,
  output logic [ADDR_SIZE-1:0]   s_araddr,
  output logic [ID_SIZE-1:0]     s_arid,
  output logic                   s_arsize,
  input  logic                   s_arready,
  // slave-side read data
  input  logic                   s_rvalid,
  input  logic [DATA_SIZE-1:0]   s_rdata,
  input  logic                   s_rlast,
  input  logic [ID_SIZE-1:0]     s_rid,
  input  logic                   s_rresp,
  output logic                   s_rready,
  // status
  output logic                   wr_grant,
  output logic                   rd_grant,
  output logic                   wr_busy,
  output logic                   rd_busy
);

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_DATA = 2'd2,
    W_RESP = 2'd3
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_e;

  wr_state_e wr_state_q, wr_state_d;
  rd_state_e rd_state_q, rd_state_d;
  logic      wr_grant_q, wr_grant_d;
  logic      rd_grant_q, rd_grant_d;
  logic      wr_ptr_q, wr_ptr_d;
  logic      rd_ptr_q, rd_ptr_d;

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_state_q <= W_IDLE;
      rd_state_q <= R_IDLE;
      wr_grant_q <= 1'b0;
      rd_grant_q <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      wr_grant_q <= wr_grant_d;
      rd_grant_q <= rd_grant_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // --------------------------------------------------------------------------
  // Write arbiter next state
  // --------------------------------------------------------------------------
  always_comb begin
    wr_state_d = wr_state_q;
    wr_grant_d = wr_grant_q;
    wr_ptr_d   = wr_ptr_q;
    case (wr_state_q)
      W_IDLE: begin
        if (|m_awvalid) begin
          // A lone requester wins outright; a tie goes to the pointer.
          wr_grant_d = (&m_awvalid) ? wr_ptr_q : m_awvalid[1];
          wr_state_d = W_ADDR;
        end
      end
      W_ADDR: if (s_awvalid && s_awready) wr_state_d = W_DATA;
      W_DATA: if (s_wvalid && s_wready) wr_state_d = W_RESP;
      W_RESP: begin
        if (s_bvalid && s_bready) begin
          wr_state_d = W_IDLE;
          // The other master gets priority on the next tie.
          wr_ptr_d   = ~wr_grant_q;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Write channel routing; everything not owned by the active phase is 0.
  // --------------------------------------------------------------------------
  always_comb begin
    s_awvalid = 1'b0;
    s_awaddr  = '0;
    s_awid    = '0;
    s_awsize  = 1'b0;
    m_awready = 2'b00;
    s_wvalid  = 1'b0;
    s_wdata   = '0;
    s_wlast   = 1'b0;
    m_wready  = 2'b00;
    s_bready  = 1'b0;
    m_bvalid  = 2'b00;
    m_bresp   = 2'b00;
    m_bid     = '0;
    case (wr_state_q)
      W_ADDR: begin
        s_awvalid             = m_awvalid[wr_grant_q];
        s_awaddr              = wr_grant_q ? m_awaddr[2*ADDR_SIZE-1:ADDR_SIZE] : m_awaddr[ADDR_SIZE-1:0];
        s_awid                = wr_grant_q ? m_awid[2*ID_SIZE-1:ID_SIZE] : m_awid[ID_SIZE-1:0];
        s_awsize              = m_awsize[wr_grant_q];
        m_awready[wr_grant_q] = s_awready;
      end
      W_DATA: begin
        s_wvalid             = m_wvalid[wr_grant_q];
        s_wdata              = wr_grant_q ? m_wdata[2*DATA_SIZE-1:DATA_SIZE] : m_wdata[DATA_SIZE-1:0];
        s_wlast              = m_wlast[wr_grant_q];
        m_wready[wr_grant_q] = s_wready;
      end
      W_RESP: begin
        m_bvalid[wr_grant_q] = s_bvalid;
        m_bresp[wr_grant_q]  = s_bresp;
        if (wr_grant_q) m_bid[2*ID_SIZE-1:ID_SIZE] = s_bid;
        else            m_bid[ID_SIZE-1:0]         = s_bid;
        s_bready             = m_bready[wr_grant_q];
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Read arbiter next state
  // --------------------------------------------------------------------------
  always_comb begin
    rd_state_d = rd_state_q;
    rd_grant_d = rd_grant_q;
    rd_ptr_d   = rd_ptr_q;
    case (rd_state_q)
      R_IDLE: begin
        if (|m_arvalid) begin
          rd_grant_d = (&m_arvalid) ? rd_ptr_q : m_arvalid[1];
          rd_state_d = R_ADDR;
        end
      end
      R_ADDR: if (s_arvalid && s_arready) rd_state_d = R_DATA;
      R_DATA: begin
        if (s_rvalid && s_rready) begin
          rd_state_d = R_IDLE;
          rd_ptr_d   = ~rd_grant_q;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Read channel routing
  // --------------------------------------------------------------------------
  always_comb begin
    s_arvalid = 1'b0;
    s_araddr  = '0;
    s_arid    = '0;
    s_arsize  = 1'b0;
    m_arready = 2'b00;
    s_rready  = 1'b0;
    m_rvalid  = 2'b00;
    m_rdata   = '0;
    m_rlast   = 2'b00;
    m_rid     = '0;
    m_rresp   = 2'b00;
    case (rd_state_q)
      R_ADDR: begin
        s_arvalid             = m_arvalid[rd_grant_q];
        s_araddr              = rd_grant_q ? m_araddr[2*ADDR_SIZE-1:ADDR_SIZE] : m_araddr[ADDR_SIZE-1:0];
        s_arid                = rd_grant_q ? m_arid[2*ID_SIZE-1:ID_SIZE] : m_arid[ID_SIZE-1:0];
        s_arsize              = m_arsize[rd_grant_q];
        m_arready[rd_grant_q] = s_arready;
      end
      R_DATA: begin
        m_rvalid[rd_grant_q] = s_rvalid;
        m_rlast[rd_grant_q]  = s_rlast;
        m_rresp[rd_grant_q]  = s_rresp;
        if (rd_grant_q) begin
          m_rdata[2*DATA_SIZE-1:DATA_SIZE] = s_rdata;
          m_rid[2*ID_SIZE-1:ID_SIZE]       = s_rid;
        end else begin
          m_rdata[DATA_SIZE-1:0] = s_rdata;
          m_rid[ID_SIZE-1:0]     = s_rid;
        end
        s_rready             = m_rready[rd_grant_q];
      end
      default: ;
    endcase
  end

  assign wr_grant = wr_grant_q;
  assign rd_grant = rd_grant_q;
  assign wr_busy  = (wr_state_q != W_IDLE);
  assign rd_busy  = (rd_state_q != R_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_arb2.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_lite_arb2
// Description : Directed self-checking bench for axi_lite_arb2. Requests are
//               pushed to per-direction scoreboards when driven and popped
//               when the arbiter presents them to the slave side.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_lite_arb2;

  localparam int D = 32;
  localparam int A = 32;
  localparam int I = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0] m_awvalid, m_awsize, m_awready, m_wvalid, m_wlast, m_wready;
  logic [1:0] m_bvalid, m_bresp, m_bready, m_arvalid, m_arsize, m_arready;
  logic [1:0] m_rvalid, m_rlast, m_rresp, m_rready;
  logic [2*A-1:0] m_awaddr, m_araddr;
  logic [2*I-1:0] m_awid, m_bid, m_arid, m_rid;
  logic [2*D-1:0] m_wdata, m_rdata;
  logic s_awvalid, s_awsize, s_awready, s_wvalid, s_wlast, s_wready;
  logic s_bvalid, s_bresp, s_bready, s_arvalid, s_arsize, s_arready;
  logic s_rvalid, s_rlast, s_rresp, s_rready;
  logic [A-1:0] s_awaddr, s_araddr;
  logic [I-1:0] s_awid, s_bid, s_arid, s_rid;
  logic [D-1:0] s_wdata, s_rdata;
  logic wr_grant, rd_grant, wr_busy, rd_busy;

  axi_lite_arb2 #(.DATA_SIZE(D), .ADDR_SIZE(A), .ID_SIZE(I)) dut (
    .clk(clk), .reset(reset),
    .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awid(m_awid), .m_awsize(m_awsize),
    .m_awready(m_awready),
    .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wlast(m_wlast), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bid(m_bid), .m_bready(m_bready),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arid(m_arid), .m_arsize(m_arsize),
    .m_arready(m_arready),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rlast(m_rlast), .m_rid(m_rid),
    .m_rresp(m_rresp), .m_rready(m_rready),
    .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awid(s_awid), .s_awsize(s_awsize),
    .s_awready(s_awready),
    .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wlast(s_wlast), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bid(s_bid), .s_bready(s_bready),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arid(s_arid), .s_arsize(s_arsize),
    .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rlast(s_rlast), .s_rid(s_rid),
    .s_rresp(s_rresp), .s_rready(s_rready),
    .wr_grant(wr_grant), .rd_grant(rd_grant), .wr_busy(wr_busy), .rd_busy(rd_busy)
  );

  typedef struct {
    logic        g;
    logic [31:0] addr;
    logic [31:0] id;
    logic [31:0] data;
  } exp_t;

  exp_t wr_q[$];
  exp_t rd_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [1:0] onehot(input logic g);
    return g ? 2'b10 : 2'b01;
  endfunction

  task automatic set_wr_req(input int m, input logic [31:0] addr, input logic [31:0] id,
                            input logic [31:0] data);
    exp_t e;
    m_awvalid[m]        = 1'b1;
    m_awaddr[m*A +: A]  = addr;
    m_awid[m*I +: I]    = id;
    m_wvalid[m]         = 1'b1;
    m_wdata[m*D +: D]   = data;
    m_wlast[m]          = 1'b1;
    e.g = m[0]; e.addr = addr; e.id = id; e.data = data;
    wr_q.push_back(e);
  endtask

  task automatic set_rd_req(input int m, input logic [31:0] addr, input logic [31:0] id,
                            input logic [31:0] data);
    exp_t e;
    m_arvalid[m]       = 1'b1;
    m_araddr[m*A +: A] = addr;
    m_arid[m*I +: I]   = id;
    e.g = m[0]; e.addr = addr; e.id = id; e.data = data;
    rd_q.push_back(e);
  endtask

  task automatic check_quiet(input string p);
    check({p, "_wr_busy"}, {63'd0, wr_busy}, 64'd0);
    check({p, "_rd_busy"}, {63'd0, rd_busy}, 64'd0);
    check({p, "_grants"}, {62'd0, wr_grant, rd_grant}, 64'd0);
    check({p, "_m_hs"}, {54'd0, m_awready, m_wready, m_bvalid, m_arready, m_rvalid}, 64'd0);
    check({p, "_s_hs"}, {59'd0, s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready}, 64'd0);
    check({p, "_s_payload"}, {s_awaddr, s_wdata} | {32'd0, s_araddr}, 64'd0);
    check({p, "_m_payload"}, m_rdata | m_bid | m_rid, 64'd0);
  endtask

  // Zero-wait slave write: arbiter idle, request pending. Ends in the idle
  // cycle after the B handshake.
  task automatic write_phases(input string p);
    exp_t e;
    if (wr_q.size() == 0) begin
      check({p, "_wr_sb_empty"}, 64'd1, 64'd0);
      return;
    end
    e = wr_q.pop_front();
    tick();
    settle();
    check({p, "_aw"}, {s_awvalid, wr_grant, m_awready, s_awaddr}, {1'b1, e.g, onehot(e.g), e.addr});
    s_bid = s_awid;
    tick();
    m_awvalid[e.g] = 1'b0;
    settle();
    check({p, "_w"}, {s_wvalid, s_wlast, m_wready, m_awready, s_wdata}, {1'b1, 1'b1, onehot(e.g), 2'b00, e.data});
    tick();
    m_wvalid[e.g] = 1'b0;
    settle();
    check({p, "_b"}, {m_bvalid, m_bresp, s_bready, m_bid}, {onehot(e.g), onehot(e.g), 1'b1, e.g ? {e.id, 32'd0} : {32'd0, e.id}});
    tick();
    settle();
    check({p, "_wr_idle"}, {63'd0, wr_busy}, 64'd0);
  endtask

  // Zero-wait slave read; ends in the idle cycle after the R handshake.
  task automatic read_phases(input string p);
    exp_t e;
    if (rd_q.size() == 0) begin
      check({p, "_rd_sb_empty"}, 64'd1, 64'd0);
      return;
    end
    e = rd_q.pop_front();
    tick();
    settle();
    check({p, "_ar"}, {s_arvalid, rd_grant, rd_busy, m_arready, s_araddr}, {1'b1, e.g, 1'b1, onehot(e.g), e.addr});
    s_rid   = s_arid;
    s_rdata = e.data;
    tick();
    m_arvalid[e.g] = 1'b0;
    settle();
    check({p, "_r_hs"}, {60'd0, m_rvalid, m_rlast}, {60'd0, onehot(e.g), onehot(e.g)});
    check({p, "_r_data"}, m_rdata, e.g ? {e.data, 32'd0} : {32'd0, e.data});
    check({p, "_r_id"}, m_rid, e.g ? {e.id, 32'd0} : {32'd0, e.id});
    tick();
    settle();
    check({p, "_rd_idle"}, {63'd0, rd_busy}, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    reset     = 1'b1;
    m_awvalid = '0; m_awaddr = '0; m_awid = '0; m_awsize = '0;
    m_wvalid  = '0; m_wdata  = '0; m_wlast = '0; m_bready = 2'b11;
    m_arvalid = '0; m_araddr = '0; m_arid = '0; m_arsize = '0; m_rready = 2'b11;
    s_awready = 1'b1; s_wready = 1'b1; s_bvalid = 1'b1; s_bresp = 1'b1; s_bid = '0;
    s_arready = 1'b1; s_rvalid = 1'b1; s_rdata = '0; s_rlast = 1'b1; s_rid = '0; s_rresp = 1'b0;

    // Reset state (slave-side inputs active, yet nothing may leak through).
    tick(); tick();
    reset = 1'b0;
    settle();
    check_quiet("reset");

    // Single write from m1, zero-wait slave.
    set_wr_req(1, 32'h10, 32'd5, 32'hDEADBEEF);
    settle();
    check("m1_pre_grant", {62'd0, s_awvalid, wr_busy}, 64'd0);
    write_phases("m1_write");

    // Both masters request three times: order m0, m1, m0.
    set_wr_req(0, 32'h100, 32'd1, 32'hA0A0_0001);
    set_wr_req(1, 32'h104, 32'd2, 32'hB1B1_0002);
    write_phases("rr_1");
    set_wr_req(0, 32'h108, 32'd3, 32'hA0A0_0003);
    write_phases("rr_2");
    write_phases("rr_3");

    // Concurrent write from m0 and read from m1.
    set_wr_req(0, 32'h20, 32'd7, 32'h1111_2222);
    set_rd_req(1, 32'h40, 32'd9, 32'hCAFE_0001);
    e = rd_q.pop_front();
    void'(wr_q.pop_front());
    tick();
    settle();
    check("conc_grants", {62'd0, wr_grant, rd_grant}, {62'd0, 1'b0, 1'b1});
    check("conc_addr", {s_awaddr, s_araddr}, {32'h20, 32'h40});
    check("conc_valid", {60'd0, s_awvalid, s_arvalid, m_arready}, {60'd0, 1'b1, 1'b1, 2'b10});
    s_bid = s_awid; s_rid = s_arid; s_rdata = e.data;
    tick();
    m_awvalid[0] = 1'b0; m_arvalid[1] = 1'b0;
    settle();
    check("conc_rvalid", {58'd0, s_wvalid, m_rvalid, m_wready, 1'b0}, {58'd0, 1'b1, 2'b10, 2'b01, 1'b0});
    check("conc_rdata", m_rdata, {32'hCAFE_0001, 32'd0});
    tick();
    m_wvalid[0] = 1'b0;
    settle();
    check("conc_b", {59'd0, m_bvalid, rd_busy, m_bid[31:0] == 32'd7, 1'b0}, {59'd0, 2'b01, 1'b0, 1'b1, 1'b0});
    tick();
    settle();
    check("conc_idle", {62'd0, wr_busy, rd_busy}, 64'd0);

    // Slave backpressure: AW held 3 cycles, B delayed 2 cycles.
    s_awready = 1'b0; s_bvalid = 1'b0;
    set_wr_req(0, 32'h30, 32'd4, 32'h3333_3333);
    e = wr_q.pop_front();
    tick();
    for (int k = 0; k < 3; k++) begin
      settle();
      check("bp_aw_hold", {s_awvalid, wr_grant, m_awready, s_awaddr}, {1'b1, 1'b0, 2'b00, e.addr});
      tick();
    end
    s_awready = 1'b1;
    settle();
    check("bp_aw_go", {60'd0, m_awready, s_wvalid, wr_busy}, {60'd0, 2'b01, 1'b0, 1'b1});
    tick();
    m_awvalid[0] = 1'b0;
    settle();
    check("bp_w", {s_wvalid, s_wdata}, {1'b1, e.data});
    tick();
    m_wvalid[0] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      settle();
      check("bp_b_hold", {60'd0, m_bvalid, s_bready, wr_busy}, {60'd0, 2'b00, 1'b1, 1'b1});
      tick();
    end
    s_bvalid = 1'b1;
    settle();
    check("bp_b_go", {61'd0, m_bvalid, wr_grant}, {61'd0, 2'b01, 1'b0});
    tick();
    settle();
    check("bp_idle", {63'd0, wr_busy}, 64'd0);

    // Reset during W_DATA of an m1 write; pointer must come back to m0.
    s_wready = 1'b0;
    set_wr_req(1, 32'h50, 32'd6, 32'h5555_5555);
    void'(wr_q.pop_front());
    tick();
    tick();
    m_awvalid[1] = 1'b0;
    settle();
    check("rst_in_wdata", {s_wvalid, wr_grant, s_wdata}, {1'b1, 1'b1, 32'h5555_5555});
    reset = 1'b1;
    tick();
    settle();
    check_quiet("mid_reset");
    reset    = 1'b0;
    s_wready = 1'b1;
    set_wr_req(0, 32'h60, 32'd10, 32'h6060_6060);
    set_wr_req(1, 32'h64, 32'd11, 32'h6464_6464);
    write_phases("post_rst_m0");
    write_phases("post_rst_m1");

    // Four back-to-back reads from m0: 3 cycles each, one idle cycle between.
    for (int k = 0; k < 4; k++) begin
      set_rd_req(0, 32'h200 + 32'(k * 4), 32'(20 + k), 32'hF00D_0000 + 32'(k));
      read_phases("b2b_read");
    end

    check("sb_drained", {32'(wr_q.size()), 32'(rd_q.size())}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
